// File: rtl/mac_sequencer_pkg.sv
// Shared types and defaults for the multiply-accumulate sequencer.
package mac_pkg;
  localparam int WIDTH   = 16;
  localparam int COUNT_W = 4;

  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, OUT} state_t;

  // Two's-complement add overflow from the sign bits of both addends and the sum.
  function automatic logic add_overflow(input logic sign_a, input logic sign_b,
                                        input logic sign_s);
    return (sign_a == sign_b) && (sign_s != sign_a);
  endfunction
endpackage

// File: rtl/mac_sequencer_if.sv
// Operand stream, multiplier link and result port of the MAC sequencer.
interface mac_sequencer_if #(
  parameter int WIDTH   = mac_pkg::WIDTH,
  parameter int COUNT_W = mac_pkg::COUNT_W
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_last;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_out;
  logic               acc_valid;
  logic               acc_ready;
  logic [WIDTH-1:0]   acc_sum;
  logic [COUNT_W-1:0] acc_count;
  logic               acc_overflow;

  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_done, mul_out, acc_ready,
    output in_ready, mul_start, mul_a, mul_b, acc_valid, acc_sum, acc_count, acc_overflow
  );

  modport master (
    output in_valid, in_a, in_b, in_last, mul_done, mul_out, acc_ready,
    input  in_ready, mul_start, mul_a, mul_b, acc_valid, acc_sum, acc_count, acc_overflow
  );
endinterface

// File: rtl/mac_sequencer_accum.sv
// Running sum with saturating pair counter and sticky signed-overflow flag.
module mac_accum
  import mac_pkg::*;
#(
  parameter int WIDTH   = mac_pkg::WIDTH,
  parameter int COUNT_W = mac_pkg::COUNT_W
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic [WIDTH-1:0]   addend_i,
  output logic [WIDTH-1:0]   sum_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               overflow_o
);
  logic [WIDTH-1:0]   sum_q, sum_d, raw_sum;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;

  assign raw_sum = sum_q + addend_i;

  always_comb begin
    sum_d      = sum_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      sum_d      = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (enable_i) begin
      sum_d      = raw_sum;
      count_d    = (&count_q) ? count_q : count_q + COUNT_W'(1);
      overflow_d = overflow_q | add_overflow(sum_q[WIDTH-1], addend_i[WIDTH-1],
                                             raw_sum[WIDTH-1]);
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sum_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign sum_o      = sum_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
endmodule

// File: rtl/mac_sequencer.sv
// Feeds operand pairs to a sequential multiplier and accumulates the products
// into a dot-product result held until downstream accepts it.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int WIDTH   = mac_pkg::WIDTH,
  parameter int COUNT_W = mac_pkg::COUNT_W
) (
  input  logic            clock,
  input  logic            reset_L,
  mac_sequencer_if.slave  bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic             last_q, last_d;
  logic             acc_en, acc_clr;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      mul_a_q <= '0;
      mul_b_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      last_q  <= last_d;
    end
  end

  // GUARD exists solely to skip a mul_done left high by the previous product.
  always_comb begin
    state_d = state_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    last_d  = last_q;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mul_a_d = bus.in_a;
          mul_b_d = bus.in_b;
          last_d  = bus.in_last;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = GUARD;
      GUARD: state_d = WAIT;
      WAIT: begin
        if (bus.mul_done) begin
          acc_en  = 1'b1;
          state_d = last_q ? OUT : IDLE;
        end
      end
      OUT: begin
        if (bus.acc_ready) begin
          acc_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mul_start = (state_q == ISSUE);
  assign bus.acc_valid = (state_q == OUT);
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;

  mac_accum #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) u_accum (
    .clock      (clock),
    .reset_L    (reset_L),
    .clear_i    (acc_clr),
    .enable_i   (acc_en),
    .addend_i   (bus.mul_out),
    .sum_o      (bus.acc_sum),
    .count_o    (bus.acc_count),
    .overflow_o (bus.acc_overflow)
  );
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a latency-programmable multiplier model.
module tb_mac_sequencer;
  localparam int W  = 16;
  localparam int CW = 4;

  logic clock   = 1'b0;
  logic reset_L = 1'b0;

  mac_sequencer_if #(.WIDTH(W), .COUNT_W(CW)) bus();

  mac_sequencer #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Multiplier model: done stays high (stale) across a new start until the
  // product is ready `mdl_lat` edges after the start edge.
  int           mdl_lat     = 1;
  int           mdl_cnt     = 0;
  logic         mdl_done    = 1'b0;
  logic [W-1:0] mdl_out     = '0;
  logic [W-1:0] mdl_prod    = '0;
  logic         preload_req = 1'b0;
  logic [W-1:0] preload_val = '0;

  function automatic logic [W-1:0] prod_of(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p[W-1:0];
  endfunction

  always @(posedge clock) begin
    if (preload_req) begin
      mdl_done <= 1'b1;
      mdl_out  <= preload_val;
    end else if (bus.mul_start) begin
      mdl_cnt  <= mdl_lat;
      mdl_prod <= prod_of(bus.mul_a, bus.mul_b);
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        mdl_done <= 1'b1;
        mdl_out  <= mdl_prod;
      end else begin
        mdl_done <= 1'b0;
      end
    end
  end

  assign bus.mul_done = mdl_done;
  assign bus.mul_out  = mdl_out;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] sum,
                               input logic [CW-1:0] cnt, input logic ovf);
    check({tag, "_sum"}, 32'(bus.acc_sum), 32'(sum));
    check({tag, "_count"}, 32'(bus.acc_count), 32'(cnt));
    check({tag, "_ovf"}, 32'(bus.acc_overflow), 32'(ovf));
  endtask

  // Called just after a negedge; returns at the negedge of the ISSUE cycle.
  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic last, input int lat);
    int n;
    mdl_lat     = lat;
    bus.in_a    = a;
    bus.in_b    = b;
    bus.in_last = last;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("accept_timeout", 32'(n >= 100), 32'(0));
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("mul_start", 32'(bus.mul_start), 32'(1));
    check("mul_a", 32'(bus.mul_a), 32'(a));
    check("mul_b", 32'(bus.mul_b), 32'(b));
  endtask

  // Polls until the sequencer leaves WAIT; the first observable cycle after
  // accumulation is lat+2 negedges past the ISSUE negedge.
  task automatic wait_accum(input int lat, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(bus.in_ready || bus.acc_valid) && n < 100);
    check("accum_latency", 32'(n), 32'(lat + 2));
    check("mul_a_held", 32'(bus.mul_a), 32'(a));
    check("mul_b_held", 32'(bus.mul_b), 32'(b));
  endtask

  task automatic accept_result();
    bus.acc_ready = 1'b1;
    @(negedge clock);
    bus.acc_ready = 1'b0;
    check("post_accept_valid", 32'(bus.acc_valid), 32'(0));
    check("post_accept_ready", 32'(bus.in_ready), 32'(1));
    check_outputs("post_accept", '0, '0, 1'b0);
  endtask

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          last;
    int            lat;
    logic          stale;
    logic [W-1:0]  exp_sum;
    logic [CW-1:0] exp_cnt;
    logic          exp_ovf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'd3,    16'd4,    1'b0, 9, 1'b0, 16'd12,   4'd1, 1'b0};
    tbl[1] = '{16'd5,    16'hFFFE, 1'b1, 9, 1'b0, 16'd2,    4'd2, 1'b0};
    tbl[2] = '{16'd7,    16'd7,    1'b1, 3, 1'b1, 16'd49,   4'd1, 1'b0};
    tbl[3] = '{16'd112,  16'd256,  1'b0, 2, 1'b0, 16'h7000, 4'd1, 1'b0};
    tbl[4] = '{16'd32,   16'd256,  1'b1, 1, 1'b0, 16'h9000, 4'd2, 1'b1};
    tbl[5] = '{16'hFFFD, 16'd5,    1'b0, 1, 1'b0, 16'hFFF1, 4'd1, 1'b0};
    tbl[6] = '{16'hFFFC, 16'hFFFA, 1'b1, 4, 1'b0, 16'd9,    4'd2, 1'b0};
    tbl[7] = '{16'hFF80, 16'd256,  1'b0, 2, 1'b0, 16'h8000, 4'd1, 1'b0};
    tbl[8] = '{16'hFFFF, 16'd1,    1'b1, 2, 1'b0, 16'h7FFF, 4'd2, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.acc_ready = 1'b0;

    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_mul_start", 32'(bus.mul_start), 32'(0));
    check("rst_mul_a", 32'(bus.mul_a), 32'(0));
    check("rst_mul_b", 32'(bus.mul_b), 32'(0));
    check("rst_acc_valid", 32'(bus.acc_valid), 32'(0));
    check_outputs("rst", '0, '0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].stale) begin
        preload_val = 16'h1234;
        preload_req = 1'b1;
        @(negedge clock);
        preload_req = 1'b0;
      end
      send_pair(tbl[i].a, tbl[i].b, tbl[i].last, tbl[i].lat);
      wait_accum(tbl[i].lat, tbl[i].a, tbl[i].b);
      $display("pair %0d a=%0h b=%0h last=%0b sum=%0h cnt=%0d ovf=%0b", i,
               tbl[i].a, tbl[i].b, tbl[i].last, bus.acc_sum, bus.acc_count, bus.acc_overflow);
      check_outputs("vec", tbl[i].exp_sum, tbl[i].exp_cnt, tbl[i].exp_ovf);
      check("vec_acc_valid", 32'(bus.acc_valid), 32'(tbl[i].last));
      check("vec_in_ready", 32'(bus.in_ready), 32'(!tbl[i].last));
      if (tbl[i].last) accept_result();
    end

    // Backpressure on the result while upstream already holds the next pair.
    send_pair(16'd2, 16'd3, 1'b1, 2);
    wait_accum(2, 16'd2, 16'd3);
    bus.in_a     = 16'd10;
    bus.in_b     = 16'd10;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      $display("hold cycle %0d acc_valid=%0b sum=%0h in_ready=%0b", k,
               bus.acc_valid, bus.acc_sum, bus.in_ready);
      check("hold_acc_valid", 32'(bus.acc_valid), 32'(1));
      check("hold_in_ready", 32'(bus.in_ready), 32'(0));
      check("hold_mul_start", 32'(bus.mul_start), 32'(0));
      check("hold_sum", 32'(bus.acc_sum), 32'(6));
    end
    bus.acc_ready = 1'b1;
    @(negedge clock);
    bus.acc_ready = 1'b0;
    check("release_in_ready", 32'(bus.in_ready), 32'(1));
    check("release_acc_valid", 32'(bus.acc_valid), 32'(0));
    check("release_sum", 32'(bus.acc_sum), 32'(0));
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("held_pair_start", 32'(bus.mul_start), 32'(1));
    check("held_pair_a", 32'(bus.mul_a), 32'(10));
    wait_accum(2, 16'd10, 16'd10);
    $display("held pair sum=%0h acc_valid=%0b", bus.acc_sum, bus.acc_valid);
    check_outputs("held", 16'd100, 4'd1, 1'b0);
    check("held_acc_valid", 32'(bus.acc_valid), 32'(1));
    accept_result();

    // Counter saturation over a 17-pair vector.
    for (int k = 1; k <= 17; k++) begin
      send_pair(16'd1, 16'd1, (k == 17), 1);
      wait_accum(1, 16'd1, 16'd1);
      $display("sat pair %0d sum=%0h cnt=%0d", k, bus.acc_sum, bus.acc_count);
      check_outputs("sat", W'(k), CW'((k > 15) ? 15 : k), 1'b0);
    end
    check("sat_acc_valid", 32'(bus.acc_valid), 32'(1));
    accept_result();

    // Reset while waiting on a slow product; the late done must be ignored.
    send_pair(16'd4, 16'd5, 1'b1, 9);
    repeat (3) @(negedge clock);
    reset_L = 1'b0;
    #1;
    $display("reset mid-op in_ready=%0b sum=%0h", bus.in_ready, bus.acc_sum);
    check("midrst_in_ready", 32'(bus.in_ready), 32'(1));
    check("midrst_mul_start", 32'(bus.mul_start), 32'(0));
    check("midrst_mul_a", 32'(bus.mul_a), 32'(0));
    check("midrst_mul_b", 32'(bus.mul_b), 32'(0));
    check("midrst_acc_valid", 32'(bus.acc_valid), 32'(0));
    check_outputs("midrst", '0, '0, 1'b0);
    @(negedge clock);
    reset_L = 1'b1;
    repeat (12) @(negedge clock);
    check("late_done_seen", 32'(bus.mul_done), 32'(1));
    check("late_in_ready", 32'(bus.in_ready), 32'(1));
    check("late_acc_valid", 32'(bus.acc_valid), 32'(0));
    check_outputs("late", '0, '0, 1'b0);

    send_pair(16'd2, 16'd2, 1'b1, 1);
    wait_accum(1, 16'd2, 16'd2);
    $display("post-reset vector sum=%0h cnt=%0d", bus.acc_sum, bus.acc_count);
    check_outputs("post_rst", 16'd4, 4'd1, 1'b0);
    accept_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Operand-feeding and result-collecting controller that sits on both sides of the sequential shift-add multiplier. It accepts a stream of signed operand pairs over a valid/ready handshake and issues one `start` pulse per pair. It waits for the multiplier's `done`, then accumulates each signed product into a running sum. When the pair flagged `last` has been accumulated, it presents the dot-product result downstream and holds it until that result is accepted.

## Interface
- `WIDTH`, 16: operand, product and accumulator width (two's complement)
- `COUNT_W`, 4: width of the pair counter
- `clock` in 1: single clock; all state on rising edge
- `reset_L` in 1: asynchronous, active-low reset
- `in_valid` in 1: operand pair present
- `in_ready` out 1: sequencer can take a pair
- `in_a`, `in_b` in WIDTH: signed operands
- `in_last` in 1: this pair closes the current vector
- `mul_start` out 1: one-cycle start pulse to the multiplier
- `mul_a`, `mul_b` out WIDTH: registered operands to the multiplier
- `mul_done` in 1: multiplier finished; may be stale-high while the multiplier is idle
- `mul_out` in WIDTH: signed product, valid while `mul_done`
- `acc_valid` out 1: result available
- `acc_ready` in 1: downstream takes the result
- `acc_sum` out WIDTH: accumulated sum, wraps mod 2^WIDTH
- `acc_count` out COUNT_W: pairs accumulated, saturates at all-ones
- `acc_overflow` out 1: sticky signed-overflow flag for the current vector

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, register `in_a`/`in_b` to `mul_a`/`mul_b`, register `in_last`, then go to ISSUE.
  - ISSUE: `mul_start`=1 for exactly this cycle, then go to GUARD.
  - GUARD: ignore `mul_done` for one cycle, because it may be stale from the previous operation. Go to WAIT.
  - WAIT: stay until `mul_done`=1. In that cycle, add `mul_out` to `acc_sum`, increment `acc_count`, and update `acc_overflow`. If the registered last flag is set, go to OUT; otherwise go to IDLE.
  - OUT: `acc_valid`=1 and `in_ready`=0. On `acc_ready`, clear `acc_sum`, `acc_count` and `acc_overflow`, then go to IDLE.
- Overflow: set when the two addend signs match and the sum sign differs. It stays set until the result is accepted.
- Operand stability: `mul_a`/`mul_b` are held constant from ISSUE until WAIT exits.
- `acc_sum`, `acc_count` and `acc_overflow` are visible at all times. They are only guaranteed final while `acc_valid`=1.
- `in_ready` and `acc_valid` are decoded from state only. Neither depends combinationally on `in_valid` or `acc_ready`.

## Timing
- Reset values: state IDLE, so `in_ready`=1 immediately after reset deasserts. `mul_start`=0, `mul_a`=`mul_b`=0, `acc_valid`=0, `acc_sum`=0, `acc_count`=0, `acc_overflow`=0.
- Pair accepted at edge N:
  - `mul_start` is high in cycle N+1.
  - The earliest `mul_done` sampled is in cycle N+3.
  - Accumulation happens at the edge ending the first WAIT cycle with `mul_done`=1.
- The next pair can be accepted in the cycle after a non-last accumulation.
- `acc_valid` rises in the cycle after the last accumulation.
- `acc_valid` with `acc_ready` already high: accepted in 1 cycle.
- `in_valid` during ISSUE/GUARD/WAIT/OUT: not accepted; the pair must be held by upstream.
- Reset mid-operation: all state clears asynchronously. Any in-flight multiplier result is ignored.
- A single-pair vector (`in_last` on the first pair) is legal.
- `acc_count` at all-ones stays at all-ones; the sum keeps accumulating.

## Structure
- Package `mac_pkg`: state enum (IDLE, ISSUE, GUARD, WAIT, OUT) and the default `WIDTH`/`COUNT_W` constants.
- One sub-module, `mac_accum`: contains the sum register, the saturating counter and the sticky overflow flag. Its controls are clear, enable and addend.

## Test plan
- Pairs (3,4), (5,−2, last); multiplier model latency 9 → `acc_valid` with `acc_sum`=2, `acc_count`=2, `acc_overflow`=0.
- Stale-high `mul_done` at start with (7,7, last) → no accumulation in GUARD; final `acc_sum`=49.
- Products 0x7000 then 0x2000 (last) → `acc_sum`=0x9000, `acc_overflow`=1; after acceptance, the next vector starts at 0 with flag 0.
- Hold `acc_ready`=0 for 5 cycles with `in_valid`=1 → `acc_valid` and the sum stay stable, `in_ready`=0, no pair consumed; release → returns to IDLE and accepts the held pair next cycle.
- 17 pairs of (1,1), last on the 17th → `acc_count`=15 (saturated), `acc_sum`=17.
- Assert `reset_L`=0 during WAIT → all outputs 0 and `in_ready`=1 after release; a late `mul_done` does not alter `acc_sum`.
